// File: rtl/fetch_unit.sv
// Instruction-fetch controller: one outstanding req/ack memory fetch, PC write-enable generation,
// IF/ID output register backed by a one-entry skid register for decode stalls.
module fetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pcwrite_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDrain, StHold} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              acc;

  assign acc       = !inst_valid_q || !stall_i;
  assign pcwrite_o = flush_i || ((state_q == StWait) && mem_ack_i);

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    // Decode consumes a valid word on every unstalled edge; reloads below override this.
    inst_valid_d = inst_valid_q && stall_i;
    if (flush_i) begin
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (!flush_i && start_i) begin
          mem_addr_d = pc_i;
          mem_req_d  = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          if (!flush_i) begin
            if (acc) begin
              inst_d       = mem_data_i;
              inst_pc_d    = mem_addr_q;
              inst_valid_d = 1'b1;
            end else begin
              skid_d    = mem_data_i;
              skid_pc_d = mem_addr_q;
              state_d   = StHold;
            end
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Request stays up until the killed fetch is acknowledged; its data is discarded.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StHold: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (!stall_i) begin
          inst_d       = skid_q;
          inst_pc_d    = skid_pc_q;
          inst_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: inputs change 1 time unit after the rising edge,
// outputs are sampled 1 time unit after that.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        pcwrite_o;
  logic        stall_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .pc_i        (pc_i),
    .pcwrite_o   (pcwrite_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o),
    .inst_valid_o(inst_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; pc_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    if (mem_req_o !== 1'b0) begin $display("FAIL rst_req got %0b want 0", mem_req_o); n_bad++; end
    n_cmp++;
    if (mem_addr_o !== 32'h0) begin $display("FAIL rst_addr got %h want 0", mem_addr_o); n_bad++; end
    n_cmp++;
    if (inst_o !== 32'h0) begin $display("FAIL rst_inst got %h want 0", inst_o); n_bad++; end
    n_cmp++;
    if (inst_pc_o !== 32'h0) begin $display("FAIL rst_inst_pc got %h want 0", inst_pc_o); n_bad++; end
    n_cmp++;
    if (inst_valid_o !== 1'b0) begin $display("FAIL rst_valid got %0b want 0", inst_valid_o); n_bad++; end
    n_cmp++;
    if (pcwrite_o !== 1'b0) begin $display("FAIL rst_pcwrite got %0b want 0", pcwrite_o); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_basic_fetch();
    start_i = 1'b1; pc_i = 32'h0;
    tick();
    mem_ack_i = 1'b1; mem_data_i = 32'h1111_1111;
    #1;
    if (mem_req_o !== 1'b1) begin $display("FAIL basic_req got %0b want 1", mem_req_o); n_bad++; end
    n_cmp++;
    if (mem_addr_o !== 32'h0) begin $display("FAIL basic_addr got %h want 0", mem_addr_o); n_bad++; end
    n_cmp++;
    if (pcwrite_o !== 1'b1) begin $display("FAIL basic_pcwrite got %0b want 1", pcwrite_o); n_bad++; end
    n_cmp++;
    tick();
    mem_ack_i = 1'b0; pc_i = 32'h4;
    #1;
    if (inst_valid_o !== 1'b1) begin $display("FAIL basic_valid got %0b want 1", inst_valid_o); n_bad++; end
    n_cmp++;
    if (inst_o !== 32'h1111_1111) begin $display("FAIL basic_inst got %h want 11111111", inst_o); n_bad++; end
    n_cmp++;
    if (inst_pc_o !== 32'h0) begin $display("FAIL basic_inst_pc got %h want 0", inst_pc_o); n_bad++; end
    n_cmp++;
    if (mem_req_o !== 1'b0) begin $display("FAIL basic_req_idle got %0b want 0", mem_req_o); n_bad++; end
    n_cmp++;
    if (pcwrite_o !== 1'b0) begin $display("FAIL basic_pcwrite_idle got %0b want 0", pcwrite_o); n_bad++; end
    n_cmp++;
    tick();
    #1;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin
      $display("FAIL basic_next_req got req=%0b addr=%h want req=1 addr=4", mem_req_o, mem_addr_o);
      n_bad++;
    end
    n_cmp++;
    if (inst_valid_o !== 1'b0) begin $display("FAIL basic_consumed got %0b want 0", inst_valid_o); n_bad++; end
    n_cmp++;
    mem_ack_i = 1'b1; mem_data_i = 32'h2222_2222; start_i = 1'b0;
    tick();
    mem_ack_i = 1'b0; pc_i = 32'h8;
    tick();
    #1;
    if (mem_req_o !== 1'b0) begin $display("FAIL basic_stop_req got %0b want 0", mem_req_o); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_latency();
    start_i = 1'b1; pc_i = 32'h10;
    tick();
    for (int c = 0; c < 3; c++) begin
      mem_ack_i = (c == 2);
      mem_data_i = (c == 2) ? 32'hA5A5_0010 : 32'hFFFF_FFFF;
      if (c == 2) start_i = 1'b0;
      #1;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10) begin
        $display("FAIL lat_req_c%0d got req=%0b addr=%h want req=1 addr=10", c, mem_req_o,
                 mem_addr_o);
        n_bad++;
      end
      n_cmp++;
      if (pcwrite_o !== (c == 2)) begin
        $display("FAIL lat_pcwrite_c%0d got %0b want %0b", c, pcwrite_o, (c == 2));
        n_bad++;
      end
      n_cmp++;
      tick();
    end
    mem_ack_i = 1'b0; pc_i = 32'h14;
    #1;
    if (inst_valid_o !== 1'b1 || inst_o !== 32'hA5A5_0010 || inst_pc_o !== 32'h10) begin
      $display("FAIL lat_out got v=%0b inst=%h pc=%h want v=1 inst=a5a50010 pc=10",
               inst_valid_o, inst_o, inst_pc_o);
      n_bad++;
    end
    n_cmp++;
    if (mem_req_o !== 1'b0) begin $display("FAIL lat_req_drop got %0b want 0", mem_req_o); n_bad++; end
    n_cmp++;
    tick();
  endtask

  task automatic test_stall_hold();
    start_i = 1'b1; pc_i = 32'h20; stall_i = 1'b1;
    tick();
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_1234;
    tick();
    mem_ack_i = 1'b0; pc_i = 32'h24;
    tick();
    mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    #1;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h24) begin
      $display("FAIL hold_req got req=%0b addr=%h want req=1 addr=24", mem_req_o, mem_addr_o);
      n_bad++;
    end
    n_cmp++;
    if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_1234) begin
      $display("FAIL hold_stalled_out got v=%0b inst=%h want v=1 inst=00001234", inst_valid_o,
               inst_o);
      n_bad++;
    end
    n_cmp++;
    if (pcwrite_o !== 1'b1) begin $display("FAIL hold_pcwrite got %0b want 1", pcwrite_o); n_bad++; end
    n_cmp++;
    tick();
    mem_ack_i = 1'b0; pc_i = 32'h28;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (mem_req_o !== 1'b0) begin $display("FAIL hold_noreq_c%0d got %0b want 0", c, mem_req_o); n_bad++; end
      n_cmp++;
      if (inst_o !== 32'h0000_1234 || inst_valid_o !== 1'b1) begin
        $display("FAIL hold_keep_c%0d got v=%0b inst=%h want v=1 inst=00001234", c,
                 inst_valid_o, inst_o);
        n_bad++;
      end
      n_cmp++;
      tick();
    end
    stall_i = 1'b0;
    tick();
    #1;
    if (inst_valid_o !== 1'b1 || inst_o !== 32'hDEAD_BEEF || inst_pc_o !== 32'h24) begin
      $display("FAIL hold_release got v=%0b inst=%h pc=%h want v=1 inst=deadbeef pc=24",
               inst_valid_o, inst_o, inst_pc_o);
      n_bad++;
    end
    n_cmp++;
    if (mem_req_o !== 1'b0) begin $display("FAIL hold_release_req got %0b want 0", mem_req_o); n_bad++; end
    n_cmp++;
    tick();
    #1;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h28) begin
      $display("FAIL hold_next_req got req=%0b addr=%h want req=1 addr=28", mem_req_o,
               mem_addr_o);
      n_bad++;
    end
    n_cmp++;
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0028; start_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_flush_drain();
    start_i = 1'b1; pc_i = 32'h40;
    tick();
    tick();
    flush_i = 1'b1;
    #1;
    if (pcwrite_o !== 1'b1) begin $display("FAIL drain_pcwrite got %0b want 1", pcwrite_o); n_bad++; end
    n_cmp++;
    tick();
    flush_i = 1'b0; pc_i = 32'h80; mem_ack_i = 1'b1; mem_data_i = 32'hBAD0_0000;
    #1;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin
      $display("FAIL drain_req got req=%0b addr=%h want req=1 addr=40", mem_req_o, mem_addr_o);
      n_bad++;
    end
    n_cmp++;
    if (pcwrite_o !== 1'b0) begin $display("FAIL drain_ack_pcwrite got %0b want 0", pcwrite_o); n_bad++; end
    n_cmp++;
    tick();
    mem_ack_i = 1'b0;
    #1;
    if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      $display("FAIL drain_discard got v=%0b req=%0b want v=0 req=0", inst_valid_o, mem_req_o);
      n_bad++;
    end
    n_cmp++;
    tick();
    #1;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h80) begin
      $display("FAIL drain_target got req=%0b addr=%h want req=1 addr=80", mem_req_o,
               mem_addr_o);
      n_bad++;
    end
    n_cmp++;
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0080; start_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_flush_ack();
    start_i = 1'b1; pc_i = 32'h90;
    tick();
    mem_ack_i = 1'b1; flush_i = 1'b1; mem_data_i = 32'hFEED_FACE; start_i = 1'b0;
    #1;
    if (pcwrite_o !== 1'b1) begin $display("FAIL flack_pcwrite got %0b want 1", pcwrite_o); n_bad++; end
    n_cmp++;
    tick();
    mem_ack_i = 1'b0; flush_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (inst_valid_o !== 1'b0 || inst_o !== 32'h0000_0080 || mem_req_o !== 1'b0) begin
        $display("FAIL flack_out_c%0d got v=%0b inst=%h req=%0b want v=0 inst=00000080 req=0",
                 c, inst_valid_o, inst_o, mem_req_o);
        n_bad++;
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_reset_in_wait();
    start_i = 1'b1; pc_i = 32'hA0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; start_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'h5555_AAAA;
    #1;
    if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      $display("FAIL rstw_out got req=%0b v=%0b addr=%h want req=0 v=0 addr=0", mem_req_o,
               inst_valid_o, mem_addr_o);
      n_bad++;
    end
    n_cmp++;
    if (pcwrite_o !== 1'b0) begin $display("FAIL rstw_late_ack_pcwrite got %0b want 0", pcwrite_o); n_bad++; end
    n_cmp++;
    tick();
    mem_ack_i = 1'b0;
    #1;
    if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || mem_req_o !== 1'b0) begin
      $display("FAIL rstw_ignored got v=%0b inst=%h req=%0b want v=0 inst=0 req=0",
               inst_valid_o, inst_o, mem_req_o);
      n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_latency();
    test_stall_hold();
    test_flush_drain();
    test_flush_ack();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
